// File: rtl/bg_lock_monitor.sv
// Bandgap lock monitor: integrates sequencer source/sink corrections into a
// signed trim code, grades fixed windows of activity and declares lock.
module bg_lock_monitor #(
    parameter int CODE_W   = 8,
    parameter int WIN_W    = 10,
    parameter int WIN_CYC  = 512,
    parameter int LOCK_TOL = 1,
    parameter int LOCK_N   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              setup_bias,
    input  logic              src_n,
    input  logic              snk,
    output logic [CODE_W-1:0] code,
    output logic [WIN_W:0]    win_net,
    output logic              win_done,
    output logic              locked,
    output logic              fault
);

    localparam int NET_W = WIN_W + 1;
    localparam int STK_W = $clog2(LOCK_N + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [1:0] S_FAULT  = 2'd3;

    localparam logic signed [CODE_W-1:0] CODE_MAX = {1'b0, {(CODE_W-1){1'b1}}};
    localparam logic signed [CODE_W-1:0] CODE_MIN = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic signed [NET_W-1:0]  NET_MAX  = {1'b0, {(NET_W-1){1'b1}}};
    localparam logic signed [NET_W-1:0]  NET_MIN  = {1'b1, {(NET_W-1){1'b0}}};
    localparam logic signed [NET_W-1:0]  TOL_HI   = NET_W'(LOCK_TOL);
    localparam logic signed [NET_W-1:0]  TOL_LO   = NET_W'(-LOCK_TOL);
    localparam logic [WIN_W-1:0]         WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [STK_W-1:0]         STK_FULL = STK_W'(LOCK_N);

    logic                     src_q;
    logic                     snk_q;
    logic [1:0]               state_q,    state_d;
    logic signed [CODE_W-1:0] code_q,     code_d;
    logic signed [NET_W-1:0]  net_q,      net_d;
    logic signed [NET_W-1:0]  win_net_q,  win_net_d;
    logic                     win_done_q, win_done_d;
    logic [WIN_W-1:0]         win_cnt_q,  win_cnt_d;
    logic [STK_W-1:0]         streak_q,   streak_d;

    logic                     up;
    logic                     dn;
    logic                     both;
    logic                     win_last;
    logic                     quiet;
    logic signed [CODE_W-1:0] code_nx;
    logic signed [NET_W-1:0]  net_nx;
    logic [STK_W-1:0]         streak_inc;

    assign up       = src_n & ~src_q;
    assign dn       = snk & ~snk_q;
    assign both     = up & dn;
    assign win_last = (win_cnt_q == WIN_LAST);

    // Saturating step of the trim code and the window net count.
    always_comb begin
        code_nx = code_q;
        net_nx  = net_q;
        if (up && !dn) begin
            if (code_q != CODE_MAX) code_nx = code_q + CODE_W'(1);
            if (net_q != NET_MAX)   net_nx  = net_q + NET_W'(1);
        end else if (dn && !up) begin
            if (code_q != CODE_MIN) code_nx = code_q - CODE_W'(1);
            if (net_q != NET_MIN)   net_nx  = net_q - NET_W'(1);
        end
    end

    // Window grading: quiet test on the final net and the capped streak.
    always_comb begin
        quiet      = (net_nx <= TOL_HI) && (net_nx >= TOL_LO);
        streak_inc = (streak_q == STK_FULL) ? streak_q
                                            : streak_q + STK_W'(1);
    end

    // Next-state logic for the monitor FSM and its datapath.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        net_d      = net_q;
        win_net_d  = win_net_q;
        win_done_d = 1'b0;
        win_cnt_d  = win_cnt_q;
        streak_d   = streak_q;
        case (state_q)
            S_IDLE: begin
                win_cnt_d = '0;
                net_d     = '0;
                streak_d  = '0;
                if (both) begin
                    state_d = S_FAULT;
                end else if (!setup_bias) begin
                    state_d = S_TRACK;
                end
            end
            S_TRACK, S_LOCKED: begin
                if (both) begin
                    state_d = S_FAULT;
                end else if (setup_bias) begin
                    state_d   = S_IDLE;
                    win_cnt_d = '0;
                    net_d     = '0;
                    streak_d  = '0;
                end else begin
                    code_d = code_nx;
                    if (win_last) begin
                        win_net_d  = net_nx;
                        win_done_d = 1'b1;
                        net_d      = '0;
                        win_cnt_d  = '0;
                        if (quiet) begin
                            streak_d = streak_inc;
                            if (streak_inc == STK_FULL) state_d = S_LOCKED;
                        end else begin
                            streak_d = '0;
                            state_d  = S_TRACK;
                        end
                    end else begin
                        net_d     = net_nx;
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Input history for rising-edge detection, sampled every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q <= 1'b0;
            snk_q <= 1'b0;
        end else begin
            src_q <= src_n;
            snk_q <= snk;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            code_q     <= '0;
            net_q      <= '0;
            win_net_q  <= '0;
            win_done_q <= 1'b0;
            win_cnt_q  <= '0;
            streak_q   <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            net_q      <= net_d;
            win_net_q  <= win_net_d;
            win_done_q <= win_done_d;
            win_cnt_q  <= win_cnt_d;
            streak_q   <= streak_d;
        end
    end

    assign code     = code_q;
    assign win_net  = win_net_q;
    assign win_done = win_done_q;
    assign locked   = (state_q == S_LOCKED);
    assign fault    = (state_q == S_FAULT);

endmodule
